intt_output_collector: RTL and testbench

- Sits directly downstream of the INTT processor.
- Captures the final-stage, n^-1-scaled output rows: CORE_COUNT cores x 2 slots x 60-bit words (two 30-bit coefficients each), written at the row address the processor presents while its output-active flag is high.
- Once a full polynomial of N coefficients is captured, streams it out in natural coefficient order over a valid/ready interface, LANES coefficients per beat.
- Provides a `can_accept` flag that upstream control uses to gate the next processor start.

---
 rtl/intt_collector_pkg.sv | 22 ++
 rtl/intt_collector_buffer.sv | 28 ++
 rtl/intt_output_collector.sv | 145 ++++++++++++++
 tb/tb_intt_output_collector.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intt_collector_pkg.sv
// intt_collector_pkg: shared widths, FSM states and geometry
// helpers for the INTT output collector.
package intt_collector_pkg;

  localparam int COEF_W = 30;
  localparam int WORD_W = 2 * COEF_W;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_t;

  function automatic int calc_rows(int log_n, int log_cores);
    return 1 << (log_n - 2 - log_cores);
  endfunction

  function automatic int calc_beats(int log_n, int log_lanes);
    return 1 << (log_n - log_lanes);
  endfunction

endpackage

// File: rtl/intt_collector_buffer.sv
// intt_collector_buffer: simple dual-port row buffer with a
// registered, stallable read port (BRAM style).
module intt_collector_buffer #(
  parameter int AW = 6,
  parameter int DW = 1920
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [1<<AW];

  // write port: one full row per cycle
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // read port: holds its output while rd_en is low
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/intt_output_collector.sv
// intt_output_collector: captures INTT output rows and streams
// the polynomial out in natural order over valid/ready.
module intt_output_collector
  import intt_collector_pkg::*;
#(
  parameter int LOG_CORE_COUNT = 4,
  parameter int LOG_N          = 12,
  parameter int LOG_LANES      = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [WORD_W-1:0]               in_data [1<<LOG_CORE_COUNT][2],
  input  logic [8:0]                      in_address,
  input  logic                            in_active,
  output logic                            can_accept,
  output logic [COEF_W*(1<<LOG_LANES)-1:0] m_data,
  output logic [LOG_N-1:0]                m_index,
  output logic                            m_valid,
  output logic                            m_last,
  input  logic                            m_ready,
  output logic                            err_overflow,
  output logic                            err_incomplete
);

  localparam int CORES  = 1 << LOG_CORE_COUNT;
  localparam int LANES  = 1 << LOG_LANES;
  localparam int ROWS   = calc_rows(LOG_N, LOG_CORE_COUNT);
  localparam int BEATS  = calc_beats(LOG_N, LOG_LANES);
  localparam int RAW    = $clog2(ROWS);
  localparam int BW     = $clog2(BEATS);
  localparam int SW     = BW - RAW;
  localparam int LANE_W = LANES * COEF_W;
  localparam int ROW_W  = CORES * 2 * WORD_W;

  state_t state, state_nx;
  logic [ROWS-1:0] bitmap, bitmap_nx;
  logic wr_en, set_inc, set_ovf;
  logic [RAW-1:0] wr_row;
  logic [CORES-1:0][1:0][WORD_W-1:0] wr_word;
  logic [(1<<SW)-1:0][LANE_W-1:0] rd_row;
  logic [BW:0] rd_b;
  logic [BW-1:0] s1_beat, m_beat;
  logic s1_v, adv, issue;
  logic unused_addr;

  assign wr_row      = in_address[RAW-1:0];
  assign unused_addr = ^in_address[8:RAW];
  assign can_accept  = (state != DRAIN);
  assign m_index     = {m_beat, {LOG_LANES{1'b0}}};
  assign adv         = !m_valid || m_ready;
  assign issue       = (state == DRAIN) && !rd_b[BW];

  // pack the core/slot words so coefficient order matches row layout
  always_comb begin
    for (int k = 0; k < CORES; k++) begin
      for (int s = 0; s < 2; s++) begin
        wr_word[k][s] = in_data[k][s];
      end
    end
  end

  intt_collector_buffer #(
    .AW (RAW),
    .DW (ROW_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_row),
    .wr_data (wr_word),
    .rd_en   (adv),
    .rd_addr (rd_b[BW-1:SW]),
    .rd_data (rd_row)
  );

  // next-state, row bitmap and capture write decode
  always_comb begin
    state_nx  = state;
    bitmap_nx = bitmap;
    wr_en     = 1'b0;
    set_inc   = 1'b0;
    set_ovf   = 1'b0;
    unique case (state)
      IDLE, CAPTURE: begin
        if (in_active) begin
          wr_en             = 1'b1;
          bitmap_nx[wr_row] = 1'b1;
          state_nx          = (&bitmap_nx) ? DRAIN : CAPTURE;
        end else if (state == CAPTURE) begin
          set_inc  = 1'b1;
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        set_ovf = in_active;
        if (m_valid && m_ready && m_last) begin
          state_nx  = IDLE;
          bitmap_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // state, bitmap and sticky error registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      bitmap         <= '0;
      err_overflow   <= 1'b0;
      err_incomplete <= 1'b0;
    end else begin
      state  <= state_nx;
      bitmap <= bitmap_nx;
      if (set_ovf) err_overflow <= 1'b1;
      if (set_inc) err_incomplete <= 1'b1;
    end
  end

  // two-stage read pipeline: row read, then lane select into output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_b    <= '0;
      s1_v    <= 1'b0;
      s1_beat <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_beat  <= '0;
      m_data  <= '0;
    end else begin
      if (state != DRAIN) rd_b <= '0;
      else if (adv && issue) rd_b <= rd_b + 1'b1;
      if (adv) begin
        s1_v    <= issue;
        s1_beat <= rd_b[BW-1:0];
        m_valid <= s1_v;
        m_last  <= s1_v && (&s1_beat);
        if (s1_v) begin
          m_beat <= s1_beat;
          m_data <= rd_row[s1_beat[SW-1:0]];
        end
      end
    end
  end

endmodule

// File: tb/tb_intt_output_collector.sv
// tb_intt_output_collector: directed scenario bench for the
// INTT output collector.
module tb_intt_output_collector;

  logic         clk = 0;
  logic         rst_n;
  logic [59:0]  in_data [16][2];
  logic [8:0]   in_address;
  logic         in_active;
  logic         can_accept;
  logic [119:0] m_data;
  logic [11:0]  m_index;
  logic         m_valid;
  logic         m_last;
  logic         m_ready;
  logic         err_overflow;
  logic         err_incomplete;

  int asserts = 0;
  int fails   = 0;
  int unstable;
  int cabad;
  int           cap_idx  [1024];
  logic [119:0] cap_dat  [1024];
  bit           cap_last [1024];

  always #5 clk = ~clk;

  intt_output_collector dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .in_address     (in_address),
    .in_active      (in_active),
    .can_accept     (can_accept),
    .m_data         (m_data),
    .m_index        (m_index),
    .m_valid        (m_valid),
    .m_last         (m_last),
    .m_ready        (m_ready),
    .err_overflow   (err_overflow),
    .err_incomplete (err_incomplete)
  );

  function automatic int bitrev6(int v);
    int r = 0;
    for (int i = 0; i < 6; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  function automatic logic [119:0] exp_beat(int x, int base);
    logic [119:0] v;
    for (int i = 0; i < 4; i++) v[i*30 +: 30] = 30'(x + i + base);
    return v;
  endfunction

  task automatic capture(input int nrows, input bit rev, input int base);
    for (int r = 0; r < nrows; r++) begin
      int row;
      row = rev ? bitrev6(r) : r;
      for (int k = 0; k < 16; k++) begin
        for (int s = 0; s < 2; s++) begin
          int idx;
          idx = ((row * 16 + k) * 2 + s) * 2;
          in_data[k][s] = {30'(idx + 1 + base), 30'(idx + base)};
        end
      end
      in_address = 9'(row + (rev ? 320 : 0));
      in_active  = 1'b1;
      @(posedge clk); #1;
    end
    in_active = 1'b0;
  endtask

  task automatic collect(input bit bp, input int ovf_beat,
                         input int stop_at, output int n);
    logic [15:0]  lfsr;
    bit           stalled, fin, ovf_sent;
    logic [119:0] pd;
    logic [11:0]  pi;
    logic         pl;
    lfsr = 16'hACE1;
    stalled = 0;
    ovf_sent = 0;
    n = 0;
    unstable = 0;
    cabad = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (stalled && (!m_valid || m_data !== pd ||
                      m_index !== pi || m_last !== pl))
        unstable++;
      if (m_valid && can_accept) cabad++;
      m_ready = bp ? lfsr[0] : 1'b1;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      in_active = 1'b0;
      if (n == ovf_beat && m_valid && !ovf_sent) begin
        for (int k = 0; k < 16; k++) begin
          in_data[k][0] = '1;
          in_data[k][1] = '1;
        end
        in_address = 9'd5;
        in_active  = 1'b1;
        ovf_sent   = 1;
      end
      fin = 0;
      if (m_valid && m_ready) begin
        if (n < 1024) begin
          cap_idx[n]  = int'(m_index);
          cap_dat[n]  = m_data;
          cap_last[n] = m_last;
        end
        if (m_last) fin = 1;
        n++;
      end
      if (n == stop_at) fin = 1;
      stalled = m_valid && !m_ready;
      pd = m_data;
      pi = m_index;
      pl = m_last;
      @(posedge clk); #1;
      if (fin) break;
    end
    in_active = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    in_active = 0;
    in_address = 0;
    m_ready = 1;
    for (int k = 0; k < 16; k++) begin
      in_data[k][0] = '0;
      in_data[k][1] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    asserts++;
    if (can_accept !== 1'b1) begin
      fails++; $display("FAIL rst_can_accept got %b want 1", can_accept);
    end
    asserts++;
    if (m_valid !== 1'b0) begin
      fails++; $display("FAIL rst_m_valid got %b want 0", m_valid);
    end
    asserts++;
    if (m_last !== 1'b0) begin
      fails++; $display("FAIL rst_m_last got %b want 0", m_last);
    end
    asserts++;
    if (m_index !== 12'd0) begin
      fails++; $display("FAIL rst_m_index got %0d want 0", m_index);
    end
    asserts++;
    if (m_data !== 120'd0) begin
      fails++; $display("FAIL rst_m_data got %h want 0", m_data);
    end
    asserts++;
    if (err_overflow !== 1'b0 || err_incomplete !== 1'b0) begin
      fails++;
      $display("FAIL rst_errs got %b%b want 00", err_overflow, err_incomplete);
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_ordered();
    int n;
    capture(64, 0, 0);
    asserts++;
    if (can_accept !== 1'b0) begin
      fails++; $display("FAIL full_drain_entry can_accept got %b want 0", can_accept);
    end
    asserts++;
    if (m_valid !== 1'b0) begin
      fails++; $display("FAIL full_lat0 m_valid got %b want 0", m_valid);
    end
    @(posedge clk); #1;
    asserts++;
    if (m_valid !== 1'b0) begin
      fails++; $display("FAIL full_lat1 m_valid got %b want 0", m_valid);
    end
    @(posedge clk); #1;
    asserts++;
    if (m_valid !== 1'b1 || m_index !== 12'd0) begin
      fails++;
      $display("FAIL full_lat2 valid/index got %b/%0d want 1/0", m_valid, m_index);
    end
    collect(0, -1, -1, n);
    asserts++;
    if (n !== 1024) begin
      fails++; $display("FAIL full_beats got %0d want 1024", n);
    end
    for (int b = 0; b < 1024; b++) begin
      asserts++;
      if (cap_idx[b] !== b * 4) begin
        fails++; $display("FAIL full_idx b%0d got %0d want %0d", b, cap_idx[b], b * 4);
      end
      asserts++;
      if (cap_dat[b] !== exp_beat(b * 4, 0)) begin
        fails++;
        $display("FAIL full_data b%0d got %h want %h", b, cap_dat[b], exp_beat(b * 4, 0));
      end
      asserts++;
      if (cap_last[b] !== (b == 1023)) begin
        fails++; $display("FAIL full_last b%0d got %b want %b", b, cap_last[b], b == 1023);
      end
    end
    asserts++;
    if (cabad !== 0) begin
      fails++; $display("FAIL full_can_accept_in_drain got %0d want 0", cabad);
    end
    asserts++;
    if (can_accept !== 1'b1 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL full_after acc/valid got %b/%b want 1/0", can_accept, m_valid);
    end
    asserts++;
    if (err_overflow !== 1'b0 || err_incomplete !== 1'b0) begin
      fails++;
      $display("FAIL full_errs got %b%b want 00", err_overflow, err_incomplete);
    end
  endtask

  task automatic test_scrambled();
    int n;
    capture(64, 1, 0);
    collect(0, -1, -1, n);
    asserts++;
    if (n !== 1024) begin
      fails++; $display("FAIL scr_beats got %0d want 1024", n);
    end
    for (int b = 0; b < 1024; b++) begin
      asserts++;
      if (cap_idx[b] !== b * 4 || cap_last[b] !== (b == 1023)) begin
        fails++;
        $display("FAIL scr_idx b%0d got %0d/%b want %0d/%b",
                 b, cap_idx[b], cap_last[b], b * 4, b == 1023);
      end
      asserts++;
      if (cap_dat[b] !== exp_beat(b * 4, 0)) begin
        fails++;
        $display("FAIL scr_data b%0d got %h want %h", b, cap_dat[b], exp_beat(b * 4, 0));
      end
    end
    asserts++;
    if (err_incomplete !== 1'b0) begin
      fails++; $display("FAIL scr_incomplete got %b want 0", err_incomplete);
    end
  endtask

  task automatic test_backpressure();
    int n;
    capture(64, 0, 5);
    collect(1, -1, -1, n);
    asserts++;
    if (n * 4 !== 4096) begin
      fails++; $display("FAIL bp_coeffs got %0d want 4096", n * 4);
    end
    asserts++;
    if (unstable !== 0) begin
      fails++; $display("FAIL bp_stable got %0d changes want 0", unstable);
    end
    for (int b = 0; b < 1024; b++) begin
      asserts++;
      if (cap_idx[b] !== b * 4 || cap_last[b] !== (b == 1023)) begin
        fails++;
        $display("FAIL bp_idx b%0d got %0d/%b want %0d/%b",
                 b, cap_idx[b], cap_last[b], b * 4, b == 1023);
      end
      asserts++;
      if (cap_dat[b] !== exp_beat(b * 4, 5)) begin
        fails++;
        $display("FAIL bp_data b%0d got %h want %h", b, cap_dat[b], exp_beat(b * 4, 5));
      end
    end
  endtask

  task automatic test_short_capture();
    int n;
    capture(32, 0, 9);
    collect(0, -1, -1, n);
    asserts++;
    if (err_incomplete !== 1'b1) begin
      fails++; $display("FAIL short_incomplete got %b want 1", err_incomplete);
    end
    asserts++;
    if (n !== 1024) begin
      fails++; $display("FAIL short_beats got %0d want 1024", n);
    end
    for (int b = 0; b < 512; b++) begin
      asserts++;
      if (cap_idx[b] !== b * 4 || cap_dat[b] !== exp_beat(b * 4, 9)) begin
        fails++;
        $display("FAIL short_data b%0d got %0d:%h want %0d:%h",
                 b, cap_idx[b], cap_dat[b], b * 4, exp_beat(b * 4, 9));
      end
    end
    asserts++;
    if (cap_last[1023] !== 1'b1 || cap_last[1022] !== 1'b0) begin
      fails++;
      $display("FAIL short_last got %b%b want 10", cap_last[1023], cap_last[1022]);
    end
  endtask

  task automatic test_overflow();
    int n;
    capture(64, 0, 7);
    collect(0, 10, -1, n);
    asserts++;
    if (err_overflow !== 1'b1) begin
      fails++; $display("FAIL ovf_flag got %b want 1", err_overflow);
    end
    asserts++;
    if (err_incomplete !== 1'b1) begin
      fails++; $display("FAIL ovf_incomplete_sticky got %b want 1", err_incomplete);
    end
    asserts++;
    if (n !== 1024) begin
      fails++; $display("FAIL ovf_beats got %0d want 1024", n);
    end
    for (int b = 0; b < 1024; b++) begin
      asserts++;
      if (cap_idx[b] !== b * 4 || cap_dat[b] !== exp_beat(b * 4, 7)) begin
        fails++;
        $display("FAIL ovf_data b%0d got %0d:%h want %0d:%h",
                 b, cap_idx[b], cap_dat[b], b * 4, exp_beat(b * 4, 7));
      end
    end
    asserts++;
    if (can_accept !== 1'b1) begin
      fails++; $display("FAIL ovf_after can_accept got %b want 1", can_accept);
    end
  endtask

  task automatic test_reset_mid_drain();
    int n;
    capture(64, 0, 0);
    collect(0, -1, 300, n);
    asserts++;
    if (n !== 300 || m_valid !== 1'b1) begin
      fails++; $display("FAIL rmd_pre got %0d/%b want 300/1", n, m_valid);
    end
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    asserts++;
    if (m_valid !== 1'b0 || can_accept !== 1'b1) begin
      fails++;
      $display("FAIL rmd_reset valid/acc got %b/%b want 0/1", m_valid, can_accept);
    end
    asserts++;
    if (err_overflow !== 1'b0 || err_incomplete !== 1'b0) begin
      fails++;
      $display("FAIL rmd_errs got %b%b want 00", err_overflow, err_incomplete);
    end
    asserts++;
    if (m_index !== 12'd0 || m_last !== 1'b0 || m_data !== 120'd0) begin
      fails++;
      $display("FAIL rmd_outs got %0d/%b/%h want 0/0/0", m_index, m_last, m_data);
    end
    capture(64, 0, 100);
    collect(0, -1, -1, n);
    asserts++;
    if (n !== 1024) begin
      fails++; $display("FAIL rmd_beats got %0d want 1024", n);
    end
    for (int b = 0; b < 1024; b++) begin
      asserts++;
      if (cap_idx[b] !== b * 4 || cap_dat[b] !== exp_beat(b * 4, 100)) begin
        fails++;
        $display("FAIL rmd_data b%0d got %0d:%h want %0d:%h",
                 b, cap_idx[b], cap_dat[b], b * 4, exp_beat(b * 4, 100));
      end
    end
    asserts++;
    if (cap_last[1023] !== 1'b1 || can_accept !== 1'b1) begin
      fails++;
      $display("FAIL rmd_end last/acc got %b/%b want 1/1", cap_last[1023], can_accept);
    end
  endtask

  initial begin
    test_reset();
    test_full_ordered();
    test_scrambled();
    test_backpressure();
    test_short_capture();
    test_overflow();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
